// File: rtl/parking_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : parking_gate_ctrl
// Description : Car-park entry gate controller for a single entry lane.
//               A car at the front sensor must present the correct keypad
//               password before the gate opens. Also tracks occupancy against
//               a capacity limit, abandons stalled sessions after a timeout,
//               and locks the lane out (with an alarm) after repeated wrong
//               passwords.
// Ports       : clk            - system clock, rising edge
//               rstn           - asynchronous active-low reset
//               front_sensor   - car present at entry
//               back_sensor    - car has passed the gate
//               exit_sensor    - car leaving (level, rising edge counted)
//               password       - keypad value, sampled when pass_valid=1
//               pass_valid     - one-cycle password strobe
//               green_LED      - gate open
//               red_LED        - stop / error / full
//               alarm          - lockout active
//               full           - occupancy == CAPACITY
//               occupancy      - cars currently parked
//               display_screen - status code
// Revision    : 1.0 - initial release
// ============================================================================
module parking_gate_ctrl #(
  parameter int                PASS_W      = 4,
  parameter logic [PASS_W-1:0] PASSWORD    = 4'hA,
  parameter int                CAPACITY    = 8,
  parameter int                CNT_W       = 4,
  parameter int                TIMEOUT_CYC = 16,
  parameter int                MAX_TRIES   = 3,
  parameter int                LOCKOUT_CYC = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              front_sensor,
  input  logic              back_sensor,
  input  logic              exit_sensor,
  input  logic [PASS_W-1:0] password,
  input  logic              pass_valid,
  output logic              green_LED,
  output logic              red_LED,
  output logic              alarm,
  output logic              full,
  output logic [CNT_W-1:0]  occupancy,
  output logic [3:0]        display_screen
);

  // One timer serves both the session timeouts and the lockout period.
  localparam int c_TMR_MAX = (TIMEOUT_CYC > LOCKOUT_CYC) ? TIMEOUT_CYC : LOCKOUT_CYC;
  localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);
  localparam int c_TRY_W   = $clog2(MAX_TRIES + 1);

  localparam logic [c_TMR_W-1:0] c_TIMEOUT_LAST = c_TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [c_TMR_W-1:0] c_LOCKOUT_LAST = c_TMR_W'(LOCKOUT_CYC - 1);
  localparam logic [c_TRY_W-1:0] c_TRY_LIMIT    = c_TRY_W'(MAX_TRIES);
  localparam logic [CNT_W-1:0]   c_CAP          = CNT_W'(CAPACITY);

  // State encoding doubles as the display code for every state.
  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_PASS  = 3'd1,
    S_RIGHT_PASS = 3'd2,
    S_WRONG_PASS = 3'd3,
    S_STOP       = 3'd4,
    S_LOCKOUT    = 3'd5
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [c_TMR_W-1:0]   r_timer, w_timer_nxt;
  logic [c_TRY_W-1:0]   r_tries, w_tries_nxt;
  logic [CNT_W-1:0]     r_occ, w_occ_nxt;
  logic                 r_full;
  logic                 r_exit_q;

  logic                 w_pass_ok;
  logic                 w_pass_bad;
  logic [c_TRY_W-1:0]   w_tries_inc;
  state_t               w_wrong_state;
  logic                 w_entry;
  logic                 w_exit_edge;

  assign w_pass_ok     = pass_valid && (password == PASSWORD);
  assign w_pass_bad    = pass_valid && (password != PASSWORD);
  assign w_tries_inc   = r_tries + 1'b1;
  assign w_wrong_state = (w_tries_inc == c_TRY_LIMIT) ? S_LOCKOUT : S_WRONG_PASS;
  assign w_exit_edge   = exit_sensor && !r_exit_q;

  // --------------------------------------------------------------------------
  // State register and counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_timer  <= '0;
      r_tries  <= '0;
      r_occ    <= '0;
      r_full   <= 1'b0;
      r_exit_q <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_timer  <= w_timer_nxt;
      r_tries  <= w_tries_nxt;
      r_occ    <= w_occ_nxt;
      r_full   <= (w_occ_nxt == c_CAP);
      r_exit_q <= exit_sensor;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_tries_nxt = r_tries;
    w_entry     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (front_sensor && !r_full) begin
          w_state_nxt = S_WAIT_PASS;
          w_timer_nxt = '0;
          w_tries_nxt = '0;
        end
      end

      S_WAIT_PASS, S_WRONG_PASS: begin
        if (w_pass_ok) begin
          w_state_nxt = S_RIGHT_PASS;
          w_timer_nxt = '0;
        end else if (w_pass_bad) begin
          w_state_nxt = w_wrong_state;
          w_tries_nxt = w_tries_inc;
          w_timer_nxt = '0;
        end else if (r_timer == c_TIMEOUT_LAST) begin
          w_state_nxt = S_IDLE;
          w_tries_nxt = '0;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end

      S_RIGHT_PASS: begin
        if (back_sensor) begin
          w_entry     = 1'b1;
          w_tries_nxt = '0;
          w_timer_nxt = '0;
          // A car still at the front sensor as the first one passes is a
          // tailgater: hold it at STOP until it presents its own password.
          w_state_nxt = front_sensor ? S_STOP : S_IDLE;
        end else if (r_timer == c_TIMEOUT_LAST) begin
          w_state_nxt = S_IDLE;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end

      S_STOP: begin
        // The tailgater may have filled the park; never open onto a full park.
        if (w_pass_ok) begin
          w_state_nxt = r_full ? S_IDLE : S_RIGHT_PASS;
          w_timer_nxt = '0;
        end else if (w_pass_bad) begin
          w_state_nxt = w_wrong_state;
          w_tries_nxt = w_tries_inc;
          w_timer_nxt = '0;
        end
      end

      S_LOCKOUT: begin
        if (r_timer == c_LOCKOUT_LAST) begin
          w_state_nxt = S_IDLE;
          w_tries_nxt = '0;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_timer_nxt = '0;
        w_tries_nxt = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Occupancy: simultaneous entry and exit cancel; both ends saturate.
  // --------------------------------------------------------------------------
  always_comb begin
    w_occ_nxt = r_occ;
    if (w_entry && !w_exit_edge) begin
      if (r_occ != c_CAP) begin
        w_occ_nxt = r_occ + 1'b1;
      end
    end else if (w_exit_edge && !w_entry) begin
      if (r_occ != '0) begin
        w_occ_nxt = r_occ - 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Moore outputs
  // --------------------------------------------------------------------------
  assign green_LED      = (r_state == S_RIGHT_PASS);
  assign red_LED        = (r_state == S_WRONG_PASS) || (r_state == S_STOP) ||
                          (r_state == S_LOCKOUT) || ((r_state == S_IDLE) && r_full);
  assign alarm          = (r_state == S_LOCKOUT);
  assign full           = r_full;
  assign occupancy      = r_occ;
  assign display_screen = ((r_state == S_IDLE) && r_full) ? 4'h6 : {1'b0, r_state};

endmodule
`default_nettype wire
